// File: rtl/inst_encoder_if.sv
// ---------------------------------------------------------------------------
// inst_encoder_if
// Bundles the decoded-field input handshake and the encoded-word output
// handshake of inst_encoder.
//   in_valid / in_ready      : field-side valid/ready
//   in_type .. in_imm        : decoded instruction fields
//   out_valid / out_ready    : word-side valid/ready
//   out_inst / out_err       : encoded word and its range/type error flag
// modport slave  : encoder view (consumes fields, produces words)
// modport master : producer/consumer view (test-program generator side)
// ---------------------------------------------------------------------------
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport slave (
        input  in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );

    modport master (
        output in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
// Packs decoded RV32 fields into a 32-bit instruction word, flags immediates
// that do not fit the format, and buffers results in a 2-entry FIFO.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high
//   flush      : synchronous clear of the output queue (counters kept)
//   bus        : inst_encoder_if.slave (field input / word output handshakes)
//   enc_count  : accepted words since reset, wrapping
//   err_count  : accepted error words since reset, saturating
// Type codes on in_type: R=0 I=1 S=2 B=3 U=4 J=5, anything else is unknown.
// ---------------------------------------------------------------------------
module inst_encoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    inst_encoder_if.slave    bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [2:0] INST_R = 3'd0;
    localparam logic [2:0] INST_I = 3'd1;
    localparam logic [2:0] INST_S = 3'd2;
    localparam logic [2:0] INST_B = 3'd3;
    localparam logic [2:0] INST_U = 3'd4;
    localparam logic [2:0] INST_J = 3'd5;

    // ------------------------------------------------------------------
    // Combinational encode of the current input fields
    // ------------------------------------------------------------------
    logic [31:0] enc_word;
    logic        enc_err;
    logic [31:0] imm;

    assign imm = bus.in_imm;

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (bus.in_type)
            INST_R: begin
                enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_rd, bus.in_opcode};
            end
            INST_I: begin
                enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
                // 12-bit signed range: bits 31..11 must be a sign copy
                enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
            end
            INST_S: begin
                enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, imm[4:0], bus.in_opcode};
                enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
            end
            INST_B: begin
                enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, imm[4:1], imm[11], bus.in_opcode};
                // halfword-aligned, 13-bit signed range
                enc_err  = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
            end
            INST_U: begin
                enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
                enc_err  = |imm[11:0];
            end
            INST_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                            bus.in_rd, bus.in_opcode};
                // halfword-aligned, 21-bit signed range
                enc_err  = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
            end
            default: begin
                enc_word = '0;
                enc_err  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO and counters
    // ------------------------------------------------------------------
    logic [31:0]      mem_inst_q [2];
    logic [31:0]      mem_inst_d [2];
    logic             mem_err_q  [2];
    logic             mem_err_d  [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic in_ready;
    logic push;
    logic pop;

    // flush blocks acceptance so a flushed cycle never bumps the counters
    assign in_ready = !flush && (occ_q != 2'd2);
    assign push     = bus.in_valid && in_ready;
    assign pop      = (occ_q != 2'd0) && bus.out_ready;

    always_comb begin
        mem_inst_d = mem_inst_q;
        mem_err_d  = mem_err_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        enc_cnt_d  = enc_cnt_q;
        err_cnt_d  = err_cnt_q;

        if (flush) begin
            occ_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                mem_inst_d[wr_ptr_q] = enc_word;
                mem_err_d[wr_ptr_q]  = enc_err;
                wr_ptr_d             = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end

        if (push) begin
            enc_cnt_d = enc_cnt_q + 1'b1;
            if (enc_err && (err_cnt_q != {ERR_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_inst_q[0] <= '0;
            mem_inst_q[1] <= '0;
            mem_err_q[0]  <= 1'b0;
            mem_err_q[1]  <= 1'b0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
            enc_cnt_q     <= '0;
            err_cnt_q     <= '0;
        end else begin
            mem_inst_q <= mem_inst_d;
            mem_err_q  <= mem_err_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            enc_cnt_q  <= enc_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // head entry is driven straight from storage, so it is stable under stall
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_inst  = mem_inst_q[rd_ptr_q];
    assign bus.out_err   = mem_err_q[rd_ptr_q];
    assign enc_count     = enc_cnt_q;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder
// Directed and randomized stimulus for inst_encoder, checked against a
// queue-based reference model that encodes from the RV32 format rules.
// ---------------------------------------------------------------------------
module tb_inst_encoder;

    localparam int T_R = 0, T_I = 1, T_S = 2, T_B = 3, T_U = 4, T_J = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    inst_encoder_if bus ();

    inst_encoder #(.CNT_W(16), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [32:0] exp_q[$];   // {err, inst}
    logic [15:0] enc_m;
    logic [7:0]  err_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model_enc(input int t, input bit [31:0] op,
            input bit [31:0] rd, input bit [31:0] rs1, input bit [31:0] rs2,
            input bit [31:0] f3, input bit [31:0] f7, input bit [31:0] imm);
        bit [31:0] w;
        bit        e;
        int        si;
        si = $signed(imm);
        w  = 0;
        e  = 0;
        case (t)
            T_R: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            T_I: begin
                e = (si < -2048) || (si > 2047);
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            T_S: begin
                e = (si < -2048) || (si > 2047);
                w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((imm & 32'h1F) << 7) | op;
            end
            T_B: begin
                e = ((imm & 32'h1) != 0) || (si < -4096) || (si > 4095);
                w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                    | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | op;
            end
            T_U: begin
                e = (imm % 4096) != 0;
                w = (imm & 32'hFFFFF000) | (rd << 7) | op;
            end
            T_J: begin
                e = ((imm & 32'h1) != 0) || (si < -(1 << 20)) || (si > (1 << 20) - 1);
                w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (rd << 7) | op;
            end
            default: begin
                e = 1;
                w = 0;
            end
        endcase
        return {e, w};
    endfunction

    task automatic drive(input int t, input int op, input int rd, input int rs1,
                         input int rs2, input int f3, input int f7, input bit [31:0] imm);
        bus.in_type   = 3'(t);
        bus.in_opcode = 7'(op);
        bus.in_rd     = 5'(rd);
        bus.in_rs1    = 5'(rs1);
        bus.in_rs2    = 5'(rs2);
        bus.in_funct3 = 3'(f3);
        bus.in_funct7 = 7'(f7);
        bus.in_imm    = imm;
    endtask

    // One clock: check DUT against model mid-cycle, then advance the model.
    task automatic tick();
        bit          m_ready, push, pop;
        logic [32:0] ent;
        @(negedge clk);
        m_ready = !flush && (exp_q.size() < 2);
        chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("out_inst", 64'(bus.out_inst), 64'(exp_q[0][31:0]));
            chk("out_err", 64'(bus.out_err), 64'(exp_q[0][32]));
        end
        chk("enc_count", 64'(enc_count), 64'(enc_m));
        chk("err_count", 64'(err_count), 64'(err_m));
        push = bus.in_valid && m_ready;
        pop  = (exp_q.size() > 0) && bus.out_ready;
        ent  = model_enc(int'(bus.in_type), 32'(bus.in_opcode), 32'(bus.in_rd),
                         32'(bus.in_rs1), 32'(bus.in_rs2), 32'(bus.in_funct3),
                         32'(bus.in_funct7), bus.in_imm);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            enc_m = 0;
            err_m = 0;
        end else begin
            if (flush) exp_q.delete();
            else begin
                if (pop) void'(exp_q.pop_front());
                if (push) exp_q.push_back(ent);
            end
            if (push) begin
                enc_m = enc_m + 16'd1;
                if (ent[32] && err_m != 8'hFF) err_m = err_m + 8'd1;
            end
        end
    endtask

    task automatic expect_head(input string tag, input logic [31:0] inst, input logic err);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        chk({tag, "_inst"}, 64'(bus.out_inst), 64'(inst));
        chk({tag, "_err"}, 64'(bus.out_err), 64'(err));
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(T_R, 0, 0, 0, 0, 0, 0, 32'h0);
        enc_m = 0;
        err_m = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_inst", 64'(bus.out_inst), 64'(0));
        chk("rst_out_err", 64'(bus.out_err), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_enc_count", 64'(enc_count), 64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));

        // directed encodings, consumer always ready
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive(T_I, 7'b0010011, 1, 0, 0, 0, 0, 32'd5);
        tick();
        bus.in_valid = 1'b0;
        expect_head("enc_i", 32'h00500093, 1'b0);
        chk("enc_i_count", 64'(enc_count), 64'(1));
        tick();

        bus.in_valid = 1'b1;
        drive(T_S, 7'b0100011, 0, 1, 2, 3'b010, 0, 32'd8);
        tick();
        bus.in_valid = 1'b0;
        expect_head("enc_s", 32'h0020A423, 1'b0);
        tick();

        bus.in_valid = 1'b1;
        drive(T_U, 7'b0110111, 5, 0, 0, 0, 0, 32'h12345000);
        tick();
        bus.in_valid = 1'b0;
        expect_head("enc_u", 32'h123452B7, 1'b0);
        tick();

        bus.in_valid = 1'b1;
        drive(T_J, 7'b1101111, 1, 0, 0, 0, 0, 32'hFFFFFFFC);
        tick();
        bus.in_valid = 1'b0;
        expect_head("enc_j", 32'hFFDFF0EF, 1'b0);
        tick();

        // error cases
        bus.in_valid = 1'b1;
        drive(T_B, 7'b1100011, 0, 1, 2, 0, 0, 32'd3);
        tick();
        bus.in_valid = 1'b0;
        chk("err_b", 64'(bus.out_err), 64'(1));
        tick();
        bus.in_valid = 1'b1;
        drive(T_I, 7'b0010011, 1, 0, 0, 0, 0, 32'd2048);
        tick();
        bus.in_valid = 1'b0;
        chk("err_i", 64'(bus.out_err), 64'(1));
        tick();
        bus.in_valid = 1'b1;
        drive(T_U, 7'b0110111, 5, 0, 0, 0, 0, 32'h12345001);
        tick();
        bus.in_valid = 1'b0;
        chk("err_u", 64'(bus.out_err), 64'(1));
        tick();
        chk("err_count_3", 64'(err_count), 64'(3));

        // backpressure: three back-to-back words with consumer stalled
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(T_R, 7'b0110011, 3, 4, 5, 0, 7'h20, 32'h0);
        tick();
        drive(T_R, 7'b0110011, 6, 7, 8, 1, 0, 32'h0);
        tick();
        drive(T_R, 7'b0110011, 9, 10, 11, 2, 0, 32'h0);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
        expect_head("bp_hold", 32'h405201B3, 1'b0);
        tick();
        tick();
        expect_head("bp_hold2", 32'h405201B3, 1'b0);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("bp_drained", 64'(exp_q.size() == 0 && bus.out_valid == 1'b0), 64'(1));

        // flush with two queued words and a pending input
        begin
            logic [15:0] enc_before;
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            drive(T_I, 7'b0000011, 2, 3, 0, 2, 0, 32'hFFFFF800);
            tick();
            tick();
            enc_before = enc_m;
            flush = 1'b1;
            tick();
            flush = 1'b0;
            bus.in_valid = 1'b0;
            chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
            chk("flush_enc_count", 64'(enc_count), 64'(enc_before));
            tick();
        end

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int t;
            bit [31:0] imm;
            t = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            case ($urandom_range(0, 3))
                0:       imm = $urandom;
                1:       imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                2:       imm = $urandom & 32'hFFFFF000;
                default: imm = 32'($signed($urandom_range(0, 4194303)) - 2097152) & ~32'h1;
            endcase
            drive(t, $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127), imm);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 40) == 0);
            rst           = ($urandom_range(0, 150) == 0);
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;

        // error counter saturation
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive(T_B, 7'b1100011, 0, 1, 2, 0, 0, 32'd3);
        repeat (260) tick();
        bus.in_valid = 1'b0;
        tick();
        chk("err_sat", 64'(err_count), 64'(8'hFF));

        // reset mid-stream
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(T_U, 7'b0010111, 4, 0, 0, 0, 0, 32'hABCDE000);
        tick();
        chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_out_inst", 64'(bus.out_inst), 64'(0));
        chk("mid_rst_out_err", 64'(bus.out_err), 64'(0));
        chk("mid_rst_enc_count", 64'(enc_count), 64'(0));
        chk("mid_rst_err_count", 64'(err_count), 64'(0));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
